// File: rtl/a_seq_mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package a_seq_mult_pkg;

    localparam int unsigned N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : a_seq_mult_pkg

// File: rtl/a_seq_mult_if.sv
// start/busy/done handshake and operand/result bus between controller and multiplier.
interface a_seq_mult_if #(
    parameter int unsigned N = a_seq_mult_pkg::N_DEF
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface : a_seq_mult_if

// File: rtl/a_n_rca.sv
// n-bit ripple-carry adder.
module a_n_rca #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         c_in,
    output logic [n-1:0] sum,
    output logic         c_out
);

    logic c;

    always_comb begin
        c   = c_in;
        sum = '0;
        for (int i = 0; i < int'(n); i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end

endmodule : a_n_rca

// File: rtl/a_seq_mult.sv
// Unsigned N x N shift-and-add multiplier: one partial-product add per RUN cycle.
module a_seq_mult
    import a_seq_mult_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned CW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    a_seq_mult_if.slave  bus
);

    state_e          state_q, state_n;
    logic [N-1:0]    m_q;
    logic [2*N-1:0]  p_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q;
    logic            load, shift;
    logic [N-1:0]    add_term;
    logic [N-1:0]    sum;
    logic            c_out;

    // Multiplicand is gated by the current multiplier LSB ahead of the adder.
    assign add_term = m_q & {N{p_q[0]}};

    a_n_rca #(.n(N)) u_rca (
        .a     (p_q[2*N-1:N]),
        .b     (add_term),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    always_comb begin
        state_n = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            busy_q  <= (state_n == RUN);
            done_q  <= (state_n == DONE);
        end
    end

    // Accumulator shifts right keeping the adder carry as the new MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            m_q   <= bus.a;
            p_q   <= {{N{1'b0}}, bus.b};
            cnt_q <= '0;
        end else if (shift) begin
            p_q   <= {c_out, sum, p_q[N-1:1]};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = p_q;

endmodule : a_seq_mult

// File: doc/a_seq_mult.md
Name: a_seq_mult

Overview:
- Unsigned N x N sequential shift-and-add multiplier.
- Consumer of the team's n-bit ripple-carry adder: the adder does one partial-product add per cycle under a small control FSM.
- Produces a 2N-bit product after N iteration cycles.
- start/busy/done handshake toward the surrounding datapath controller.

Parameters:
- N, 4, operand width in bits (N >= 2).
- CW, 3, counter width; must satisfy 2^CW > N (default valid for N = 4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  N  multiplicand, captured on the accepted start edge
- b  input  N  multiplier, captured on the accepted start edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, high while in DONE
- product  output  2N  result register; valid while done is high and held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE; busy = 0; done = 0; product = 0; counter = 0; multiplicand register = 0.
  - Reset mid-RUN aborts the operation; no done is produced.
- Registers:
  - M[N-1:0]: multiplicand.
  - P[2N-1:0]: accumulator; high half is the partial sum, low half is the remaining multiplier.
  - cnt[CW-1:0]: iteration count.
  - product is P.
- State IDLE:
  - On a clock edge with start = 1: M <= a, P <= {N'b0, b}, cnt <= 0, state -> RUN.
  - Otherwise hold.
- State RUN (busy = 1), one iteration per edge:
  - If P[0] = 1, adder inputs are P[2N-1:N], M, c_in = 0, giving sum[N-1:0] and c_out. Otherwise the add term is 0 and c_out = 0.
  - P <= {c_out, sum, P[N-1:1]}, a logical right shift that keeps the carry.
  - cnt <= cnt + 1.
  - When cnt = N-1 at the edge, that iteration completes and state -> DONE.
  - Exactly N RUN cycles.
- State DONE (done = 1, busy = 0), lasts exactly one cycle:
  - If start = 1 at the DONE edge, the new operands load exactly as in IDLE and state -> RUN (back-to-back, no idle gap).
  - Otherwise state -> IDLE.
- Latency: start accepted at edge k; busy high in cycles k+1 .. k+N; done high in cycle k+N+1; product valid from edge k+N.
- start while in RUN is ignored. Operands a and b may change freely after the accepted edge.
- product holds its final value in IDLE. It changes only on an accepted start, when P reloads and the high half clears.
- Width rule: the result is exact for all operands. Max (2^N - 1)^2 fits in 2N bits, so the carry out of the add is never lost.
- busy and done are decoded from registered state only, with no combinational path from start. They are never both high.

Decomposition:
- Shared package/header holds:
  - State encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10; 2'b11 is illegal and returns to IDLE.
  - Default N.
- One sub-module: the team's existing n-bit ripple-carry adder (a_n_rca), instantiated with n = N and c_in tied to 0.
- The add-term gating (M AND P[0]) is done in this block ahead of the adder.
- FSM, counter and shift register are inline.

Test Plan:
- N=4, a=3, b=5, single start pulse: busy high 4 cycles, then done high 1 cycle, product = 15 (8'h0F); product is still 15 three cycles later in IDLE.
- a=15, b=15: product = 225 (8'hE1). Checks carry retention on every iteration.
- a=0, b=9 and a=9, b=0: product = 0 both times; done timing identical to a nonzero case.
- start pulsed again during RUN of a=6, b=7, with a and b changed to 1: the extra start is ignored; product = 42; exactly one done pulse.
- Back-to-back, start held high continuously: a=2, b=3 then a=4, b=5 (operands changed while in DONE). done pulses 5 cycles apart; products 6 then 20; no IDLE cycle between.
- rst_n asserted low asynchronously mid-clock during the 2nd RUN cycle of a=13, b=11: busy, done and product go to 0 immediately, no done follows, state is IDLE. After release a new start with a=13, b=11 gives 143.
